iq_tone_gen: RTL

IQ_TONE_GEN -- requirements
Module: iq_tone_gen

---
 rtl/iq_tone_pkg.sv | 33 +++
 rtl/iq_sin_lut.sv | 56 +++++
 rtl/iq_tone_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/iq_tone_pkg.sv
// iq_tone_pkg: FSM state type, dither LFSR constants and elaboration helpers.
// Quarter-wave entries come from an integer Taylor series, so no real math is needed.
package iq_tone_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    function automatic bit levels_ok(int offset, int amp, int out_w);
        return (offset - amp >= 0) && (offset + amp <= (1 << out_w) - 1);
    endfunction

    // round(amp * sin(k/2^aw * pi/2)), evaluated in Q30 fixed point
    function automatic int lut_entry(int k, int aw, int amp);
        longint x;
        longint term;
        longint acc;
        x = (HALF_PI_Q30 * longint'(k)) >>> aw;
        term = x;
        acc = x;
        for (int n = 1; n < 10; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = term / longint'((2 * n) * (2 * n + 1));
            if (n % 2 == 1) acc = acc - term;
            else acc = acc + term;
        end
        return int'((acc * longint'(amp) + (longint'(1) <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/iq_sin_lut.sv
// iq_sin_lut: quarter-wave table folded into a full-circle sin/cos lookup.
// One registered stage; values are signed offsets around zero.
module iq_sin_lut import iq_tone_pkg::*; #(
    parameter int OUT_W  = 5,
    parameter int LUT_AW = 8,
    parameter int AMP    = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic [LUT_AW+1:0]       phase,
    output logic signed [OUT_W+1:0] sin_val,
    output logic signed [OUT_W+1:0] cos_val
);

    localparam int N  = 1 << LUT_AW;
    localparam int SW = OUT_W + 2;

    // N+1 entries so the mirrored index N (exact quarter turn) needs no special case
    logic [OUT_W-1:0] tbl [0:N];

    for (genvar k = 0; k <= N; k++) begin : g_tbl
        assign tbl[k] = OUT_W'(lut_entry(k, LUT_AW, AMP));
    end

    function automatic logic [LUT_AW:0] mirror(logic [LUT_AW+1:0] p);
        logic [LUT_AW:0] idx;
        idx = {1'b0, p[LUT_AW-1:0]};
        return p[LUT_AW] ? (LUT_AW+1)'(N) - idx : idx;
    endfunction

    function automatic logic signed [SW-1:0] signed_mag(logic neg, logic [OUT_W-1:0] mag);
        logic signed [SW-1:0] m;
        m = signed'({2'b00, mag});
        return neg ? -m : m;
    endfunction

    logic [LUT_AW+1:0] cphase;
    logic signed [SW-1:0] sin_nxt;
    logic signed [SW-1:0] cos_nxt;

    assign cphase  = phase + (LUT_AW+2)'(N);
    assign sin_nxt = signed_mag(phase[LUT_AW+1], tbl[mirror(phase)]);
    assign cos_nxt = signed_mag(cphase[LUT_AW+1], tbl[mirror(cphase)]);

    always_ff @(posedge clock) begin
        if (reset) begin
            sin_val <= '0;
            cos_val <= '0;
        end else if (en) begin
            sin_val <= sin_nxt;
            cos_val <= cos_nxt;
        end
    end

endmodule

// File: rtl/iq_tone_gen.sv
// iq_tone_gen: FSK-steered phase accumulator feeding a quarter-wave I/Q LUT.
// Define IQ_TONE_GEN_DITHER_EN for independent +/-1 LSB LFSR dither on i and q.
module iq_tone_gen import iq_tone_pkg::*; #(
    parameter int OUT_W   = 5,
    parameter int SYM_W   = 3,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 8,
    parameter int DIV     = 1,
    parameter int OFFSET  = 16,
    parameter int AMP     = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [SYM_W-1:0]   sym,
    input  logic [PHASE_W-1:0] base_fcw,
    input  logic [PHASE_W-1:0] step_fcw,
    output logic [OUT_W-1:0]   i_out,
    output logic [OUT_W-1:0]   q_out,
    output logic               sample_valid,
    output logic               running
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = OUT_W + 2;
    localparam logic signed [SW-1:0] VMAX = SW'((1 << OUT_W) - 1);
    localparam logic signed [SW-1:0] VOFF = SW'(OFFSET);

    if (!levels_ok(OFFSET, AMP, OUT_W)) begin : g_bad_levels
        $error("iq_tone_gen: OFFSET +/- AMP does not fit in OUT_W bits");
    end

    state_t               state;
    logic [CW-1:0]        count;
    logic [PHASE_W-1:0]   phase;
    logic [PHASE_W-1:0]   phase_nxt;
    logic                 strobe;
    logic                 adv;
    logic                 in_flight;
    logic signed [SW-1:0] sin_val;
    logic signed [SW-1:0] cos_val;
    logic signed [SW-1:0] i_raw;
    logic signed [SW-1:0] q_raw;

    assign strobe    = enable && (count == CW'(DIV - 1));
    assign adv       = strobe && (state == RUN);
    assign phase_nxt = phase + base_fcw + step_fcw * PHASE_W'(sym);

    iq_sin_lut #(
        .OUT_W  (OUT_W),
        .LUT_AW (LUT_AW),
        .AMP    (AMP)
    ) u_lut (
        .clock   (clock),
        .reset   (reset),
        .en      (adv),
        .phase   (phase_nxt[PHASE_W-1 -: LUT_AW+2]),
        .sin_val (sin_val),
        .cos_val (cos_val)
    );

`ifdef IQ_TONE_GEN_DITHER_EN
    logic [15:0]          lfsr;
    logic signed [SW-1:0] di;
    logic signed [SW-1:0] dq;

    always_ff @(posedge clock) begin
        if (reset) lfsr <= LFSR_SEED;
        else if (strobe) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
    end

    // bit pair 01 -> +1, 10 -> -1, 00/11 -> 0
    assign di    = {{(SW-1){lfsr[1] & ~lfsr[0]}}, lfsr[1] ^ lfsr[0]};
    assign dq    = {{(SW-1){lfsr[3] & ~lfsr[2]}}, lfsr[3] ^ lfsr[2]};
    assign i_raw = VOFF + sin_val + di;
    assign q_raw = VOFF + cos_val + dq;
`else
    assign i_raw = VOFF + sin_val;
    assign q_raw = VOFF + cos_val;
`endif

    function automatic logic [OUT_W-1:0] clamp(logic signed [SW-1:0] v);
        if (v < 0) return '0;
        if (v > VMAX) return '1;
        return v[OUT_W-1:0];
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            running      <= 1'b0;
            count        <= '0;
            phase        <= '0;
            in_flight    <= 1'b0;
            sample_valid <= 1'b0;
            i_out        <= OUT_W'(OFFSET);
            q_out        <= OUT_W'(OFFSET);
        end else begin
            count        <= (!enable || strobe) ? '0 : count + 1'b1;
            in_flight    <= adv;
            sample_valid <= in_flight && enable;
            if (in_flight && enable) begin
                i_out <= clamp(i_raw);
                q_out <= clamp(q_raw);
            end
            unique case (state)
                IDLE: begin
                    if (strobe && sym != '0) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        phase   <= '0;
                    end else if (strobe) begin
                        phase <= phase_nxt;
                    end
                end
            endcase
        end
    end

endmodule
